// File: rtl/lsu_misalign_seq.sv
// Splits misaligned EX-stage loads/stores into two aligned word accesses on the data bus.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests return an error instead of splitting.
module lsu_misalign_seq #(
  parameter int unsigned GNT_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic [31:0] adder_result_i,
  output logic        lsu_addr_incr_req_o,
  output logic [31:0] lsu_addr_last_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic        busy_o,
  output logic        resp_valid_o,
  output logic        resp_err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT1 = 3'd1,
    RV1  = 3'd2,
    GNT2 = 3'd3,
    RV2  = 3'd4,
    TRAP = 3'd5
  } state_e;

  state_e      state, state_next;
  logic        we_q;
  logic [1:0]  type_q;
  logic [31:0] cnt;
  logic        mis_q, timeout, trap_hit, resp_fire, resp_err_d;

  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] off);
    case (t)
      2'b01:   misaligned = (off == 2'd3);
      2'b10:   misaligned = 1'b0;
      default: misaligned = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] be_p1(input logic [1:0] t, input logic [1:0] off);
    case (t)
      2'b01:   be_p1 = 4'(4'b0011 << off);
      2'b10:   be_p1 = 4'(4'b0001 << off);
      default: be_p1 = 4'(4'b1111 << off);
    endcase
  endfunction

  function automatic logic [3:0] be_p2(input logic [1:0] t, input logic [1:0] off);
    be_p2 = 4'b0000;
    case (t)
      2'b01:   if (off == 2'd3) be_p2 = 4'b0001;
      2'b10:   be_p2 = 4'b0000;
      default: begin
        case (off)
          2'd1:    be_p2 = 4'b0001;
          2'd2:    be_p2 = 4'b0011;
          2'd3:    be_p2 = 4'b0111;
          default: be_p2 = 4'b0000;
        endcase
      end
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic INCR_EN = 1'b0;
  assign trap_hit = (state == IDLE) && lsu_req_i && misaligned(lsu_type_i, adder_result_i[1:0]);
`else
  localparam logic INCR_EN = 1'b1;
  assign trap_hit = 1'b0;
`endif

  assign mis_q   = misaligned(type_q, lsu_addr_last_o[1:0]);
  assign timeout = (GNT_TIMEOUT != 0) && (cnt == GNT_TIMEOUT) && ((state == GNT1) || (state == GNT2));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Request attributes are captured once so both phases see the same access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lsu_addr_last_o <= 32'd0;
      we_q            <= 1'b0;
      type_q          <= 2'b00;
      cnt             <= 32'd0;
      resp_valid_o    <= 1'b0;
      resp_err_o      <= 1'b0;
    end else begin
      if ((state == IDLE) && lsu_req_i) begin
        lsu_addr_last_o <= adder_result_i;
        we_q            <= lsu_we_i;
        type_q          <= lsu_type_i;
      end
      if ((GNT_TIMEOUT != 0) && ((state == GNT1) || (state == GNT2)) && !data_gnt_i && !timeout)
        cnt <= cnt + 32'd1;
      else
        cnt <= 32'd0;
      resp_valid_o <= resp_fire;
      resp_err_o   <= resp_fire & resp_err_d;
    end
  end

  always_comb begin
    state_next = state;
    resp_fire  = 1'b0;
    resp_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (trap_hit) begin
          state_next = TRAP;
          resp_fire  = 1'b1;
          resp_err_d = 1'b1;
        end else if (lsu_req_i) begin
          state_next = data_gnt_i ? RV1 : GNT1;
        end
      end
      GNT1, GNT2: begin
        if (timeout) begin
          state_next = IDLE;
          resp_fire  = 1'b1;
          resp_err_d = 1'b1;
        end else if (data_gnt_i) begin
          state_next = (state == GNT1) ? RV1 : RV2;
        end
      end
      RV1: begin
        if (data_rvalid_i) begin
          if (!mis_q || data_err_i) begin
            state_next = IDLE;
            resp_fire  = 1'b1;
            resp_err_d = data_err_i;
          end else begin
            state_next = GNT2;
          end
        end
      end
      RV2: begin
        if (data_rvalid_i) begin
          state_next = IDLE;
          resp_fire  = 1'b1;
          resp_err_d = data_err_i;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus fields are forced to zero whenever no request is presented.
  always_comb begin
    data_req_o          = 1'b0;
    data_we_o           = 1'b0;
    data_addr_o         = 32'd0;
    data_be_o           = 4'b0000;
    lsu_addr_incr_req_o = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_req_i && !trap_hit) begin
          data_req_o  = 1'b1;
          data_we_o   = lsu_we_i;
          data_addr_o = {adder_result_i[31:2], 2'b00};
          data_be_o   = be_p1(lsu_type_i, adder_result_i[1:0]);
        end
      end
      GNT1: begin
        if (!timeout) begin
          data_req_o  = 1'b1;
          data_we_o   = we_q;
          data_addr_o = {lsu_addr_last_o[31:2], 2'b00};
          data_be_o   = be_p1(type_q, lsu_addr_last_o[1:0]);
        end
      end
      GNT2: begin
        lsu_addr_incr_req_o = INCR_EN;
        if (!timeout) begin
          data_req_o  = 1'b1;
          data_we_o   = we_q;
          data_addr_o = {adder_result_i[31:2], 2'b00};
          data_be_o   = be_p2(type_q, lsu_addr_last_o[1:0]);
        end
      end
      default: ;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Randomized and directed bench for lsu_misalign_seq; bus beats are predicted from the bytes
// each access touches, independent of any byte-enable table.
module tb_lsu_misalign_seq;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  logic [1:0]  lsu_type;
  logic [31:0] ea, adder_result;
  logic        incr;
  logic [31:0] addr_last;
  logic        data_req, data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic        data_gnt, data_rvalid, data_err;
  logic        busy, resp_valid, resp_err;

  int total = 0;
  int bad   = 0;

  lsu_misalign_seq #(.GNT_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
    .adder_result_i(adder_result),
    .lsu_addr_incr_req_o(incr), .lsu_addr_last_o(addr_last),
    .data_req_o(data_req), .data_we_o(data_we), .data_addr_o(data_addr), .data_be_o(data_be),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_err_i(data_err),
    .busy_o(busy), .resp_valid_o(resp_valid), .resp_err_o(resp_err)
  );

  // ALU stand-in: operand A switches to the held address when the sequencer asks for it.
  assign adder_result = incr ? (addr_last + 32'd4) : ea;

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic noise();
    lsu_req  = 1'($urandom);
    lsu_we   = 1'($urandom);
    lsu_type = 2'($urandom);
    ea       = $urandom;
  endtask

  // Reference: walk the bytes of the access and sort them into the first and next word.
  function automatic void model(input logic [31:0] a, input logic [1:0] t,
                                output logic [31:0] w1, output logic [3:0] b1,
                                output logic [31:0] w2, output logic [3:0] b2, output bit two);
    int n;
    logic [31:0] byte_a;
    n  = (t == 2'b01) ? 2 : (t == 2'b10) ? 1 : 4;
    w1 = a & ~32'd3;
    w2 = w1 + 32'd4;
    b1 = 4'b0000;
    b2 = 4'b0000;
    for (int k = 0; k < n; k++) begin
      byte_a = a + 32'(k);
      if ((byte_a & ~32'd3) == w1) b1[byte_a[1:0]] = 1'b1;
      else                         b2[byte_a[1:0]] = 1'b1;
    end
    two = (b2 != 4'b0000);
  endfunction

  task automatic do_phase(input int ph, input logic [31:0] a, input logic [1:0] t, input logic we,
                          input logic [31:0] w, input logic [3:0] b, input int gd, input int rd,
                          input logic er, output bit timed_out);
    int drop_c;
    timed_out = 1'b0;
    drop_c = (ph == 1) ? int'(TO) + 1 : int'(TO);
    for (int c = 0; c < 64; c++) begin
      step();
      if (ph == 1 && c == 0) begin
        lsu_req = 1'b1; lsu_we = we; lsu_type = t; ea = a;
      end else begin
        noise();
      end
      data_gnt    = (c == gd);
      data_rvalid = 1'($urandom);
      data_err    = 1'($urandom);
      sample();
      if (gd < 0 && c == drop_c) begin
        chk("timeout_req_drop", 32'(data_req), 32'd0);
        timed_out = 1'b1;
        break;
      end
      chk("req", 32'(data_req), 32'd1);
      chk("addr", data_addr, w);
      chk("be", 32'(data_be), 32'(b));
      chk("we", 32'(data_we), 32'(we));
      chk("incr", 32'(incr), (ph == 2) ? 32'd1 : 32'd0);
      chk("busy_req", 32'(busy), (ph == 1 && c == 0) ? 32'd0 : 32'd1);
      chk("resp_idle", 32'(resp_valid), 32'd0);
      if (ph == 2 || c > 0) chk("addr_last", addr_last, a);
      if (c == gd) break;
    end
    if (!timed_out) begin
      for (int j = 0; j <= rd; j++) begin
        step();
        noise();
        data_gnt    = 1'($urandom);
        data_rvalid = (j == rd);
        data_err    = (j == rd) ? er : 1'($urandom);
        sample();
        chk("req_rv", 32'(data_req), 32'd0);
        chk("busy_rv", 32'(busy), 32'd1);
        chk("resp_rv", 32'(resp_valid), 32'd0);
        chk("incr_rv", 32'(incr), 32'd0);
      end
    end
  endtask

  task automatic do_access(input logic [31:0] a, input logic [1:0] t, input logic we,
                           input int gd0, input int rd0, input logic er0,
                           input int gd1, input int rd1, input logic er1);
    logic [31:0] w1, w2;
    logic [3:0]  b1, b2;
    bit          two, to;
    logic        exp_err;
    model(a, t, w1, b1, w2, b2, two);
`ifdef LSU_MISALIGN_TRAP_EN
    if (two) begin
      step();
      lsu_req = 1'b1; lsu_we = we; lsu_type = t; ea = a;
      data_gnt = 1'b1; data_rvalid = 1'b0; data_err = 1'b0;
      sample();
      chk("trap_no_req", 32'(data_req), 32'd0);
      step();
      lsu_req = 1'b0; data_gnt = 1'b0;
      sample();
      chk("trap_resp", 32'(resp_valid), 32'd1);
      chk("trap_err", 32'(resp_err), 32'd1);
      chk("trap_busy", 32'(busy), 32'd1);
      return;
    end
`endif
    do_phase(1, a, t, we, w1, b1, gd0, rd0, er0, to);
    exp_err = to | er0;
    if (!to && two && !er0) begin
      do_phase(2, a, t, we, w2, b2, gd1, rd1, er1, to);
      exp_err = to | er1;
    end
    step();
    lsu_req = 1'b0; data_gnt = 1'b0; ea = $urandom;
    data_rvalid = 1'($urandom); data_err = 1'($urandom);
    sample();
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("busy_done", 32'(busy), 32'd0);
    chk("req_done", 32'(data_req), 32'd0);
  endtask

  initial begin
    logic [31:0] w1, w2;
    logic [3:0]  b1, b2;
    bit          two, to;

    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00; ea = 32'd0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0;
    repeat (3) step();
    lsu_req = 1'b1; ea = 32'h1234_5677;
    sample();
    chk("rst_addr_last", addr_last, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_incr", 32'(incr), 32'd0);
    step();
    lsu_req = 1'b0; rst_n = 1'b1;
    sample();
    chk("idle_req", 32'(data_req), 32'd0);
    chk("idle_addr", data_addr, 32'd0);
    chk("idle_be", 32'(data_be), 32'd0);

    // Directed cases.
    do_access(32'h0000_1000, 2'b00, 1'b0, 0, 1, 1'b0, 0, 0, 1'b0);
    do_access(32'h0000_1003, 2'b00, 1'b1, 1, 0, 1'b0, 0, 2, 1'b0);
    do_access(32'h0000_2003, 2'b01, 1'b0, 3, 1, 1'b0, 3, 1, 1'b0);
    do_access(32'h0000_3001, 2'b00, 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
    do_access(32'hFFFF_FFFD, 2'b00, 1'b1, 0, 0, 1'b0, 2, 0, 1'b0);
    do_access(32'h0000_2002, 2'b01, 1'b1, 2, 0, 1'b0, 0, 0, 1'b0);
    do_access(32'h0000_7003, 2'b10, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    do_access(32'h0000_8006, 2'b11, 1'b0, 1, 1, 1'b0, 1, 1, 1'b1);
    do_access(32'h0000_4000, 2'b00, 1'b0, -1, 0, 1'b0, 0, 0, 1'b0);
    do_access(32'h0000_4002, 2'b00, 1'b1, 0, 0, 1'b0, -1, 0, 1'b0);

`ifndef LSU_MISALIGN_TRAP_EN
    // Reset while waiting for the second grant, then a stale response.
    model(32'h0000_5001, 2'b00, w1, b1, w2, b2, two);
    do_phase(1, 32'h0000_5001, 2'b00, 1'b0, w1, b1, 0, 0, 1'b0, to);
    step();
    lsu_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0;
    sample();
    chk("gnt2_req", 32'(data_req), 32'd1);
    chk("gnt2_incr", 32'(incr), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(data_req), 32'd0);
    chk("arst_incr", 32'(incr), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", data_addr, 32'd0);
    chk("arst_addr_last", addr_last, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    data_rvalid = 1'b1;
    sample();
    chk("late_rv_req", 32'(data_req), 32'd0);
    step();
    data_rvalid = 1'b0;
    sample();
    chk("late_rv_resp", 32'(resp_valid), 32'd0);
    chk("late_rv_busy", 32'(busy), 32'd0);
    do_access(32'h0000_6000, 2'b00, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
`endif

    // Randomized accesses with bounded grant/response delays.
    for (int n = 0; n < 60; n++) begin
      do_access($urandom, 2'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
